// File: rtl/bist_ora_misr.sv
// -----------------------------------------------------------------------------
// bist_ora_misr
//
// Output response analyser for the full-adder BIST. This block sits at the
// receiving end of the LFSR test-pattern path. It compresses each CUT response
// {cout,sum} into a multiple-input signature register (MISR). After PATTERNS
// responses have been accepted, it compares the signature with GOLDEN_SIG and
// reports done/pass/fail.
//
// Optional feature macro: ORA_TIMEOUT_EN
//   When defined, a watchdog counts idle cycles while compressing. If TIMEOUT
//   idle cycles pass with no response accepted, it ends the run as a failure.
//   When undefined, there is no watchdog logic and timeout is tied to 0.
//
// Ports
//   clock       in   1       system clock, rising edge
//   reset       in   1       asynchronous, active-high reset
//   start       in   1       one-cycle pulse: (re)arm a compression run
//   resp_valid  in   1       resp_in holds a valid CUT response this cycle
//   resp_in     in   RESP_W  CUT response, zero-extended to MISR_W
//   signature   out  MISR_W  current MISR contents
//   done        out  1       run finished; held until start/reset
//   pass        out  1       done && signature == GOLDEN_SIG
//   fail        out  1       done && (mismatch or timeout)
//   timeout     out  1       watchdog fired
// -----------------------------------------------------------------------------
module bist_ora_misr #(
    parameter int                 RESP_W     = 2,
    parameter int                 MISR_W     = 3,
    parameter logic [MISR_W-1:0]  POLY       = 3'b011,
    parameter logic [MISR_W-1:0]  SEED       = 3'b000,
    parameter int                 PATTERNS   = 7,
    parameter int                 CNT_W      = 3,
    parameter logic [MISR_W-1:0]  GOLDEN_SIG = 3'b000,
    parameter int                 TIMEOUT    = 15
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic              resp_valid,
    input  logic [RESP_W-1:0] resp_in,
    output logic [MISR_W-1:0] signature,
    output logic              done,
    output logic              pass,
    output logic              fail,
    output logic              timeout
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_COMPRESS,
        S_COMPARE,
        S_DONE
    } state_t;

    state_t             state;
    logic [CNT_W-1:0]   count;
    logic [CNT_W-1:0]   count_inc;
    logic [MISR_W-1:0]  resp_ext;
    logic [MISR_W-1:0]  sig_next;

    assign resp_ext  = MISR_W'(resp_in);
    assign count_inc = count + 1'b1;

    // Shift left. When the bit shifted out was 1, fold it back in through the
    // feedback taps. Then XOR the new response into the register.
    always_comb begin
        sig_next = {signature[MISR_W-2:0], 1'b0}
                 ^ (signature[MISR_W-1] ? POLY : '0)
                 ^ resp_ext;
    end

`ifdef ORA_TIMEOUT_EN
    localparam int IDLE_W = $clog2(TIMEOUT + 1);
    logic [IDLE_W-1:0] idle_cnt;
`else
    assign timeout = 1'b0;
`endif

    // NOTE: all state is updated with non-blocking assignments. Every
    // register then samples the pre-edge values, so the MISR shift and the
    // counter update see a consistent snapshot.
    // NOTE: the reset is asynchronous. An active-high reset clears the
    // outputs immediately, without waiting for a clock edge, so a run that
    // is aborted mid-way never shows a partial result.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state     <= S_IDLE;
            signature <= SEED;
            count     <= '0;
            done      <= 1'b0;
            pass      <= 1'b0;
            fail      <= 1'b0;
`ifdef ORA_TIMEOUT_EN
            timeout   <= 1'b0;
            idle_cnt  <= '0;
`endif
        end else if (start) begin
            // start overrides everything, including a response in the same cycle
            state     <= S_COMPRESS;
            signature <= SEED;
            count     <= '0;
            done      <= 1'b0;
            pass      <= 1'b0;
            fail      <= 1'b0;
`ifdef ORA_TIMEOUT_EN
            timeout   <= 1'b0;
            idle_cnt  <= '0;
`endif
        end else begin
            case (state)
                S_COMPRESS: begin
                    if (resp_valid) begin
                        signature <= sig_next;
                        count     <= count_inc;
`ifdef ORA_TIMEOUT_EN
                        idle_cnt  <= '0;
`endif
                        if (count_inc == CNT_W'(PATTERNS)) begin
                            state <= S_COMPARE;
                        end
                    end
`ifdef ORA_TIMEOUT_EN
                    else if (idle_cnt == IDLE_W'(TIMEOUT - 1)) begin
                        // The TIMEOUT-th consecutive idle cycle ends the run.
                        // The signature is left as it is.
                        timeout <= 1'b1;
                        fail    <= 1'b1;
                        pass    <= 1'b0;
                        done    <= 1'b1;
                        state   <= S_DONE;
                    end else begin
                        idle_cnt <= idle_cnt + 1'b1;
                    end
`endif
                end
                S_COMPARE: begin
                    pass  <= (signature == GOLDEN_SIG);
                    fail  <= (signature != GOLDEN_SIG);
                    done  <= 1'b1;
                    state <= S_DONE;
                end
                S_DONE: begin
                    // Results and signature are held until the next start.
                end
                default: begin
                    // IDLE: responses are ignored until the block is armed.
                end
            endcase
        end
    end

endmodule
